// File: rtl/aes_req_scheduler_if.sv
// Signal bundle between two AES job requesters, the scheduler, the AES core
// and the response consumer.
interface aes_req_scheduler_if;
  // Every valid/ready pair is a strict handshake: a transfer happens on the
  // rising edge where both are high; the source holds valid and its payload
  // stable until then, and ready may depend combinationally on valid.
  logic         req0_valid;
  logic         req0_ready;
  logic [127:0] req0_key;
  logic [127:0] req0_text;
  logic         req1_valid;
  logic         req1_ready;
  logic [127:0] req1_key;
  logic [127:0] req1_text;

  logic         core_ld;
  logic [127:0] core_key;
  logic [127:0] core_text_in;
  logic         core_done;
  logic [127:0] core_text_out;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_id;
  logic         rsp_err;
  logic         busy;

  modport slave (
    input  req0_valid, req0_key, req0_text,
    input  req1_valid, req1_key, req1_text,
    input  core_done, core_text_out, rsp_ready,
    output req0_ready, req1_ready,
    output core_ld, core_key, core_text_in,
    output rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_key, req0_text,
    output req1_valid, req1_key, req1_text,
    output core_done, core_text_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  core_ld, core_key, core_text_in,
    input  rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );
endinterface

// File: rtl/aes_req_scheduler.sv
// Round-robin scheduler that feeds jobs from two requesters into a single AES
// core, with a WAIT timeout that turns a stuck core into an error response.
module aes_req_scheduler #(
  parameter int TIMEOUT = 20
) (
  input  logic              clk,
  input  logic              rst,
  aes_req_scheduler_if.slave bus,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [4:0] TO_CNT  = 5'(TIMEOUT);
  localparam logic [4:0] CNT_MAX = 5'h1f;

  logic [1:0]   state;
  logic         last_grant;
  logic [127:0] cap_key;
  logic [127:0] cap_text;
  logic         cap_id;
  logic [4:0]   wait_cnt;
  logic [127:0] rsp_data_q;
  logic         rsp_err_q;

  logic grant0;
  logic grant1;
  logic take0;
  logic take1;

  // On a tie the requester that did not own the previous response wins.
  // Ready is gated by reset so nothing is offered while the block is held.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    take0  = rst & (state == S_IDLE) & grant0;
    take1  = rst & (state == S_IDLE) & grant1;
  end

  assign bus.req0_ready   = take0;
  assign bus.req1_ready   = take1;
  assign bus.core_ld      = (state == S_LOAD);
  assign bus.core_key     = cap_key;
  assign bus.core_text_in = cap_text;
  assign bus.rsp_valid    = (state == S_RESP);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_id       = cap_id;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = (state != S_IDLE);
  assign dbg_state        = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      cap_key    <= '0;
      cap_text   <= '0;
      cap_id     <= 1'b0;
      wait_cnt   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take0 | take1) begin
            cap_key  <= take1 ? bus.req1_key  : bus.req0_key;
            cap_text <= take1 ? bus.req1_text : bus.req0_text;
            cap_id   <= take1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving in the timeout cycle still counts as success.
          if (bus.core_done) begin
            rsp_data_q <= bus.core_text_out;
            rsp_err_q  <= 1'b0;
            state      <= S_RESP;
          end else if (wait_cnt == TO_CNT) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            state      <= S_RESP;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 5'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            last_grant <= cap_id;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Randomised bench for aes_req_scheduler: a job-level reference model predicts
// grants, core load timing and every response; a negedge monitor scores them.
module tb_aes_req_scheduler;

  localparam int TIMEOUT = 20;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  aes_req_scheduler_if bus ();

  aes_req_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [129:0] exp_q[$];       // {id, err, data}
  int           exp_cyc_q[$];   // cycle at which rsp_valid must appear
  int           core_k_q[$];    // WAIT index at which the core model answers (-1 never)
  logic [127:0] core_res_q[$];
  int           grant_q[$];

  bit           model_busy = 1'b0;
  bit           model_last = 1'b1;
  int           since = 0;
  logic [127:0] m_key, m_text;
  logic [127:0] last_rsp_data;
  bit           last_rsp_err;
  int           n_rsp = 0;
  int           pending_k[2];

  int  rr_mode = 0;     // 0: rsp_ready=1, 1: random, 2: held low
  bit  spurious_en = 1'b0;

  task automatic check(input string name, input logic [259:0] act, input logic [259:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // What the stand-in AES core returns: the FIPS-197 vector for its own key and
  // plaintext, an arbitrary mixing function for everything else.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
    logic [127:0] kv, tv, av, mix;
    kv  = 128'h000102030405060708090a0b0c0d0e0f;
    tv  = 128'h00112233445566778899aabbccddeeff;
    av  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    mix = 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
    if (k == kv && t == tv) return av;
    return k ^ {t[63:0], t[127:64]} ^ mix;
  endfunction

  function automatic int rand_k();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return -1;
    if (sel == 1) return TIMEOUT;
    if (sel == 2) return TIMEOUT + $urandom_range(1, 4);
    return $urandom_range(0, 12);
  endfunction

  // ---------------- monitor + reference model ----------------
  bit           e0, e1, exp_rv, a_ok;
  int           a_id, a_k;
  logic [127:0] a_key, a_text, a_res;

  always @(negedge clk) begin
    if (!rst) begin
      check("reset_ctrl", {dbg_state, bus.req0_ready, bus.req1_ready, bus.core_ld,
                           bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.busy}, '0);
      check("reset_data", {bus.rsp_data, bus.core_key}, '0);
      check("reset_text_in", bus.core_text_in, '0);
      exp_q.delete(); exp_cyc_q.delete(); core_k_q.delete(); core_res_q.delete();
      grant_q.delete();
      model_busy = 1'b0;
      model_last = 1'b1;
      since      = 0;
    end else begin
      if (model_busy) since++;
      e0 = !model_busy && bus.req0_valid && (!bus.req1_valid || model_last);
      e1 = !model_busy && bus.req1_valid && (!bus.req0_valid || !model_last);
      check("req_ready", {bus.req0_ready, bus.req1_ready}, {e0, e1});
      check("busy", bus.busy, model_busy);
      check("core_ld", bus.core_ld, model_busy && since == 1);
      if (model_busy && since >= 1)
        check("core_operands", {bus.core_key, bus.core_text_in}, {m_key, m_text});

      exp_rv = model_busy && exp_cyc_q.size() > 0 && cyc >= exp_cyc_q[0];
      check("rsp_valid", bus.rsp_valid, exp_rv);
      if (bus.rsp_valid && exp_rv) begin
        check("rsp_payload", {bus.rsp_id, bus.rsp_err, bus.rsp_data}, exp_q[0]);
        if (bus.rsp_ready) begin
          model_last    = exp_q[0][129];
          last_rsp_data = bus.rsp_data;
          last_rsp_err  = bus.rsp_err;
          n_rsp++;
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
          model_busy = 1'b0;
        end
      end

      if (e0 || e1) begin
        a_id   = e1 ? 1 : 0;
        a_key  = e1 ? bus.req1_key  : bus.req0_key;
        a_text = e1 ? bus.req1_text : bus.req0_text;
        a_k    = pending_k[a_id];
        a_res  = core_fn(a_key, a_text);
        a_ok   = (a_k >= 0) && (a_k <= TIMEOUT);
        exp_q.push_back({a_id[0], !a_ok, a_ok ? a_res : 128'h0});
        exp_cyc_q.push_back(cyc + 3 + (a_ok ? a_k : TIMEOUT));
        core_k_q.push_back(a_k);
        core_res_q.push_back(a_res);
        grant_q.push_back(a_id);
        m_key      = a_key;
        m_text     = a_text;
        model_busy = 1'b1;
        since      = 0;
      end
    end
  end

  // ---------------- AES core stand-in ----------------
  bit           core_active = 1'b0;
  int           core_cnt;
  logic [127:0] core_res;
  int           c_k;

  initial begin
    bus.core_done     = 1'b0;
    bus.core_text_out = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.core_done     = 1'b0;
      bus.core_text_out = rnd128();
      if (!rst) begin
        core_active = 1'b0;
      end else if (bus.core_ld && core_k_q.size() > 0) begin
        c_k         = core_k_q.pop_front();
        core_res    = core_res_q.pop_front();
        core_cnt    = c_k;
        core_active = (c_k >= 0);
      end else if (core_active) begin
        if (core_cnt == 0) begin
          bus.core_done     = 1'b1;
          bus.core_text_out = core_res;
          core_active       = 1'b0;
        end else begin
          core_cnt--;
        end
      end else if (spurious_en) begin
        bus.core_done = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- response consumer ----------------
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int id, input logic [127:0] key, input logic [127:0] text, input int k);
    int t;
    t = 0;
    pending_k[id] = k;
    if (id == 0) begin
      bus.req0_key = key; bus.req0_text = text; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_key = key; bus.req1_text = text; bus.req1_valid = 1'b1;
    end
    do begin
      @(negedge clk);
      t++;
    end while (!(id == 0 ? bus.req0_ready : bus.req1_ready) && t < 500);
    if (t >= 500) check("accept_timeout", id == 0 ? bus.req0_ready : bus.req1_ready, 1);
    @(posedge clk);
    #1;
    if (id == 0) bus.req0_valid = 1'b0;
    else         bus.req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((model_busy || bus.req0_valid || bus.req1_valid) && t < 1000);
    if (t >= 1000) check("drain_timeout", model_busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  int n_before;
  int t_bp;

  initial begin
    rst = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_key = '0; bus.req0_text = '0;
    bus.req1_valid = 1'b0; bus.req1_key = '0; bus.req1_text = '0;
    tick(3);
    rst = 1'b1;
    tick(1);

    // Known-answer job, core answers 10 cycles after the load strobe.
    send(0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 9);
    wait_idle();
    check("aes_vector", last_rsp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("aes_vector_err", last_rsp_err, 0);

    // Core never answers, then a normal job.
    send(0, rnd128(), rnd128(), -1);
    wait_idle();
    check("timeout_err", last_rsp_err, 1);
    check("timeout_data", last_rsp_data, 0);
    send(1, rnd128(), rnd128(), 5);
    wait_idle();
    check("after_timeout_err", last_rsp_err, 0);

    // Done exactly at the timeout count, and one cycle too late.
    send(1, rnd128(), rnd128(), TIMEOUT);
    wait_idle();
    check("tie_err", last_rsp_err, 0);
    send(0, rnd128(), rnd128(), TIMEOUT + 1);
    wait_idle();
    check("late_done_err", last_rsp_err, 1);

    // Response backpressure with a competing request and a noisy core.
    rr_mode = 2;
    send(0, rnd128(), rnd128(), 3);
    fork
      send(1, rnd128(), rnd128(), 4);
    join_none
    t_bp = 0;
    do begin
      @(negedge clk);
      t_bp++;
    end while (!bus.rsp_valid && t_bp < 100);
    if (t_bp >= 100) check("bp_rsp_timeout", bus.rsp_valid, 1);
    tick(1);
    spurious_en = 1'b1;
    tick(15);
    spurious_en = 1'b0;
    rr_mode = 0;
    wait_idle();

    // Contention straight out of reset: grants must alternate 0,1,0,1.
    rst = 1'b0;
    fork
      begin tick(2); rst = 1'b1; end
      begin
        send(0, rnd128(), rnd128(), $urandom_range(0, 6));
        send(0, rnd128(), rnd128(), $urandom_range(0, 6));
      end
      begin
        send(1, rnd128(), rnd128(), $urandom_range(0, 6));
        send(1, rnd128(), rnd128(), $urandom_range(0, 6));
      end
    join
    wait_idle();
    check("grant_count", grant_q.size(), 4);
    if (grant_q.size() == 4)
      check("grant_order", {grant_q[0][0], grant_q[1][0], grant_q[2][0], grant_q[3][0]}, 4'b0101);

    // Reset in the middle of WAIT (count 5) drops the job without a response.
    n_before = n_rsp;
    send(0, rnd128(), rnd128(), -1);
    tick(6);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    check("aborted_no_rsp", n_rsp, n_before);
    send(1, rnd128(), rnd128(), 7);
    wait_idle();
    check("fresh_job_rsp", n_rsp, n_before + 1);
    check("fresh_job_err", last_rsp_err, 0);

    // Random traffic from both requesters with a random consumer.
    rr_mode = 1;
    fork
      begin
        repeat (12) begin
          tick($urandom_range(0, 3));
          send(0, rnd128(), rnd128(), rand_k());
        end
      end
      begin
        repeat (12) begin
          tick($urandom_range(0, 3));
          send(1, rnd128(), rnd128(), rand_k());
        end
      end
    join
    rr_mode = 0;
    wait_idle();
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
